// File: rtl/aes_out_serializer.sv
// ---------------------------------------------------------------------------
// aes_out_serializer
//
// Sits behind the pipelined AES-128 core. Every ciphertext block that leaves
// the core (aes_dout_valid pulse) is captured into a small block FIFO and then
// streamed out as four 32-bit words, most-significant word first. The core
// cannot stall, so the block also counts blocks still inside the core and
// raises credit_ok only while a newly issued block is guaranteed a FIFO slot.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   blk_issue       pulse: a block entered the core this cycle
//   aes_dout        128-bit ciphertext from the core
//   aes_dout_valid  pulse qualifying aes_dout
//   credit_ok       fifo_level + inflight < DEPTH
//   m_data          current output word
//   m_valid         output word valid (FIFO not empty)
//   m_ready         downstream accepts m_data
//   m_last          fourth word of a block
//   fifo_level      number of blocks stored
//   overflow        sticky: a block was dropped because the FIFO was full
//   issue_err       sticky: blk_issue seen while credit_ok was low
//
// Output handshake: a word moves when m_valid && m_ready are both high at a
// rising edge. m_valid never depends on m_ready, and while m_valid is high
// and m_ready is low, m_data/m_valid/m_last hold their values.
// ---------------------------------------------------------------------------
module aes_out_serializer #(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         blk_issue,
  input  logic [127:0]                 aes_dout,
  input  logic                         aes_dout_valid,
  output logic                         credit_ok,
  output logic [31:0]                  m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         overflow,
  output logic                         issue_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  // Sum width wide enough for fifo_level + inflight without wrapping.
  localparam int SW = ((LW > IW) ? LW : IW) + 1;

  logic [127:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [1:0]    r_idx;
  logic [IW-1:0] r_inflight;
  logic          r_overflow;
  logic          r_issue_err;

  logic          w_full;
  logic          w_empty;
  logic          w_xfer;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [SW-1:0] w_sum;
  logic          w_credit;
  logic [127:0]  w_head_blk;
  logic [31:0]   w_word;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_xfer  = !w_empty && m_ready;
  // The head block leaves only when its last word is accepted.
  assign w_pop   = w_xfer && (r_idx == 2'd3);
  // A full FIFO still accepts a block when the head pops in the same cycle.
  assign w_push  = aes_dout_valid && (!w_full || w_pop);
  assign w_drop  = aes_dout_valid && w_full && !w_pop;

  assign w_sum    = SW'(r_level) + SW'(r_inflight);
  assign w_credit = (w_sum < SW'(DEPTH));

  // Word select on the head block, most-significant word first.
  always_comb begin
    w_head_blk = r_mem[r_rd_ptr];
    w_word     = w_head_blk[127:96];
    case (r_idx)
      2'd0: w_word = w_head_blk[127:96];
      2'd1: w_word = w_head_blk[95:64];
      2'd2: w_word = w_head_blk[63:32];
      2'd3: w_word = w_head_blk[31:0];
      default: w_word = w_head_blk[127:96];
    endcase
  end

  // Block storage carries no reset: the pointers alone define valid entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= aes_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_idx       <= '0;
      r_inflight  <= '0;
      r_overflow  <= 1'b0;
      r_issue_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      // Index wraps 3 -> 0 naturally, in step with the pop.
      if (w_xfer) begin
        r_idx <= r_idx + 2'd1;
      end

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase

      // Issue and completion in the same cycle cancel out.
      if (blk_issue && !aes_dout_valid) begin
        if (r_inflight != IW'(MAX_INFLIGHT)) begin
          r_inflight <= r_inflight + IW'(1);
        end
      end else if (aes_dout_valid && !blk_issue) begin
        if (r_inflight != '0) begin
          r_inflight <= r_inflight - IW'(1);
        end
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (blk_issue && !w_credit) begin
        r_issue_err <= 1'b1;
      end
    end
  end

  assign credit_ok  = w_credit;
  assign m_valid    = !w_empty;
  assign m_data     = w_word;
  assign m_last     = !w_empty && (r_idx == 2'd3);
  assign fifo_level = r_level;
  assign overflow   = r_overflow;
  assign issue_err  = r_issue_err;

endmodule

// File: tb/tb_aes_out_serializer.sv
module tb_aes_out_serializer;

  logic         clk;
  logic         rst;
  logic         blk_issue;
  logic [127:0] aes_dout;
  logic         aes_dout_valid;
  logic         credit_ok;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic [2:0]   fifo_level;
  logic         overflow;
  logic         issue_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected output words: {last, data}.
  logic [32:0] exp_q[$];

  aes_out_serializer #(.DEPTH(4), .MAX_INFLIGHT(15)) dut (
    .clk            (clk),
    .rst            (rst),
    .blk_issue      (blk_issue),
    .aes_dout       (aes_dout),
    .aes_dout_valid (aes_dout_valid),
    .credit_ok      (credit_ok),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .issue_err      (issue_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] blk(input logic [7:0] k);
    return {8'h10, k, 16'h0000, 8'h20, k, 16'h1111, 8'h30, k, 16'h2222, 8'h40, k, 16'h3333};
  endfunction

  task automatic sb_add(input logic [127:0] b);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({(i == 3), b[127 - 32*i -: 32]});
    end
  endtask

  task automatic push_blk(input logic [127:0] b, input bit accept);
    aes_dout       = b;
    aes_dout_valid = 1'b1;
    if (accept) sb_add(b);
    tick();
    aes_dout_valid = 1'b0;
  endtask

  task automatic issue_one();
    blk_issue = 1'b1;
    tick();
    blk_issue = 1'b0;
  endtask

  task automatic drain(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (fifo_level != 3'd0 && n < max_cyc) begin
      tick();
      n++;
    end
    check_eq({tag, "_level"}, 128'(fifo_level), 128'(0));
    check_eq({tag, "_sb_empty"}, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic check_clean(input string tag);
    check_eq({tag, "_m_valid"},   128'(m_valid),    128'(0));
    check_eq({tag, "_m_last"},    128'(m_last),     128'(0));
    check_eq({tag, "_level"},     128'(fifo_level), 128'(0));
    check_eq({tag, "_credit"},    128'(credit_ok),  128'(1));
    check_eq({tag, "_overflow"},  128'(overflow),   128'(0));
    check_eq({tag, "_issue_err"}, 128'(issue_err),  128'(0));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [32:0] exp_w;
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() != 0) exp_w = exp_q.pop_front();
      else exp_w = 'x;
      check_eq("word", 128'({m_last, m_data}), 128'(exp_w));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst            = 1'b1;
    blk_issue      = 1'b0;
    aes_dout       = '0;
    aes_dout_valid = 1'b0;
    m_ready        = 1'b0;

    // Reset state
    tick();
    tick();
    check_clean("reset");
    rst = 1'b0;

    // Single block, 9-cycle core latency
    m_ready = 1'b1;
    issue_one();
    check_eq("t1_credit_after_issue", 128'(credit_ok), 128'(1));
    repeat (8) tick();
    check_eq("t1_valid_before", 128'(m_valid), 128'(0));
    push_blk(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
    check_eq("t1_valid",  128'(m_valid),    128'(1));
    check_eq("t1_w0",     128'(m_data),     128'(32'h00112233));
    check_eq("t1_last0",  128'(m_last),     128'(0));
    check_eq("t1_level1", 128'(fifo_level), 128'(1));
    tick();
    check_eq("t1_w1", 128'(m_data), 128'(32'h44556677));
    tick();
    check_eq("t1_w2", 128'(m_data), 128'(32'h8899AABB));
    tick();
    check_eq("t1_w3",    128'(m_data), 128'(32'hCCDDEEFF));
    check_eq("t1_last3", 128'(m_last), 128'(1));
    tick();
    check_eq("t1_valid_end", 128'(m_valid),    128'(0));
    check_eq("t1_level_end", 128'(fifo_level), 128'(0));
    check_eq("t1_credit_end", 128'(credit_ok), 128'(1));

    // Backpressure
    m_ready = 1'b0;
    push_blk(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_hold_data",  128'(m_data),  128'(32'h00112233));
      check_eq("t2_hold_valid", 128'(m_valid), 128'(1));
      tick();
    end
    check_eq("t2_hold_last", 128'(m_last), 128'(0));
    for (int i = 0; i < 8; i++) begin
      m_ready = ((i % 2) == 0);
      tick();
      if (i == 0) check_eq("t2_after_first", 128'(m_data), 128'(32'h44556677));
    end
    m_ready = 1'b0;
    check_eq("t2_level_end", 128'(fifo_level), 128'(0));
    check_eq("t2_sb_empty",  128'(exp_q.size()), 128'(0));

    // Credit: four issues consume the credit, the fifth is an error
    for (int k = 1; k <= 4; k++) begin
      issue_one();
      check_eq("t3_credit", 128'(credit_ok), 128'(k < 4));
    end
    check_eq("t3_no_err", 128'(issue_err), 128'(0));
    issue_one();
    check_eq("t3_issue_err", 128'(issue_err), 128'(1));

    // Overflow: fill with four blocks, fifth is dropped
    for (int k = 1; k <= 4; k++) push_blk(blk(8'(k)), 1'b1);
    check_eq("t4_level_full", 128'(fifo_level), 128'(4));
    check_eq("t4_no_ovf",     128'(overflow),   128'(0));
    check_eq("t4_credit_full", 128'(credit_ok), 128'(0));
    push_blk(blk(8'd5), 1'b0);
    check_eq("t4_ovf",        128'(overflow),   128'(1));
    check_eq("t4_level_kept", 128'(fifo_level), 128'(4));
    m_ready = 1'b1;
    drain(40, "t4_drain");
    check_eq("t4_credit_back", 128'(credit_ok), 128'(1));

    // Clear sticky flags
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    check_clean("rst2");

    // Full FIFO, word3 transfers while a new block arrives
    m_ready = 1'b0;
    for (int k = 6; k <= 9; k++) push_blk(blk(8'(k)), 1'b1);
    check_eq("t5_level_full", 128'(fifo_level), 128'(4));
    m_ready = 1'b1;
    repeat (3) tick();
    check_eq("t5_last",  128'(m_last), 128'(1));
    check_eq("t5_w3",    128'(m_data), 128'(32'h40063333));
    push_blk(blk(8'd10), 1'b1);
    check_eq("t5_no_ovf", 128'(overflow),   128'(0));
    check_eq("t5_level",  128'(fifo_level), 128'(4));
    drain(60, "t5_drain");

    // Reset mid-stream while word1 of block 2 is presented
    m_ready = 1'b0;
    repeat (3) issue_one();
    push_blk(blk(8'd11), 1'b1);
    push_blk(blk(8'd12), 1'b1);
    m_ready = 1'b1;
    repeat (5) tick();
    check_eq("t6_pre_w1",    128'(m_data),  128'(32'h200C1111));
    check_eq("t6_pre_valid", 128'(m_valid), 128'(1));
    rst = 1'b1;
    exp_q.delete();
    tick();
    check_clean("t6_rst");
    rst = 1'b0;
    // In-flight count restarted from 0: three issues keep credit, a fourth does not.
    repeat (3) issue_one();
    check_eq("t6_credit3", 128'(credit_ok), 128'(1));
    issue_one();
    check_eq("t6_credit4", 128'(credit_ok), 128'(0));
    check_eq("t6_no_err",  128'(issue_err), 128'(0));

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
